// File: rtl/nr_divide.sv
// Unsigned 16/16 divider: Newton-Raphson reciprocal refinement on one shared multiplier,
// quotient estimate, then step-wise correction to an exact floor quotient and remainder.
module nr_divide #(
    parameter int unsigned ITER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] n_in,
    input  logic [15:0] d_in,
    input  logic [15:0] a_in,
    input  logic [15:0] x_in,
    input  logic [3:0]  s_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q_out,
    output logic [15:0] r_out,
    output logic        dz_out
);

    typedef enum logic [2:0] {
        StIdle,
        StItA,
        StItB,
        StQuot,
        StRem,
        StFix,
        StDone
    } state_e;

    state_e      state_q;
    logic [15:0] n_q;
    logic [15:0] d_q;
    logic [15:0] a_q;
    logic [15:0] x_q;
    logic [3:0]  s_q;
    logic [16:0] e_q;
    logic [15:0] q_q;
    logic [17:0] r_q;
    logic [1:0]  iter_q;
    logic        out_valid_q;
    logic        dz_q;

    logic [15:0] mul_a;
    logic [16:0] mul_b;
    logic [32:0] prod;

    // Single shared multiplier; the operand pair is chosen by the current state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            StItA:   begin mul_a = a_q; mul_b = {1'b0, x_q}; end
            StItB:   begin mul_a = x_q; mul_b = e_q;         end
            StQuot:  begin mul_a = n_q; mul_b = {1'b0, x_q}; end
            StRem:   begin mul_a = q_q; mul_b = {1'b0, d_q}; end
            default: begin mul_a = '0;  mul_b = '0;          end
        endcase
    end

    assign prod = {17'b0, mul_a} * {16'b0, mul_b};

    logic [16:0] e_next;
    logic [15:0] x_next;
    logic [4:0]  q_shift;
    logic [15:0] q_est;
    logic [17:0] r_next;
    logic        r_neg;
    logic        r_big;
    logic        last_iter;

    // e = 2 - a*x in Q1.15, kept 17 bits wide so a slightly low estimate still fits.
    assign e_next    = 17'h10000 - {1'b0, prod[31:16]};
    assign x_next    = (prod[32:31] != 2'b00) ? 16'hFFFF : prod[30:15];
    assign q_shift   = 5'd31 - {1'b0, s_q};
    assign q_est     = 16'(prod[31:0] >> q_shift);
    assign r_next    = {2'b00, n_q} - prod[17:0];
    assign r_neg     = r_q[17];
    assign r_big     = !r_q[17] && (r_q >= {2'b00, d_q});
    assign last_iter = (iter_q == 2'(ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            d_q         <= '0;
            a_q         <= '0;
            x_q         <= '0;
            s_q         <= '0;
            e_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        n_q    <= n_in;
                        d_q    <= d_in;
                        a_q    <= a_in;
                        x_q    <= x_in;
                        s_q    <= s_in;
                        iter_q <= '0;
                        if (d_in == 16'd0) begin
                            q_q         <= 16'hFFFF;
                            r_q         <= {2'b00, n_in};
                            dz_q        <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= StItA;
                        end
                    end
                end
                StItA: begin
                    e_q     <= e_next;
                    state_q <= StItB;
                end
                StItB: begin
                    x_q     <= x_next;
                    iter_q  <= iter_q + 2'd1;
                    state_q <= last_iter ? StQuot : StItA;
                end
                StQuot: begin
                    q_q     <= q_est;
                    state_q <= StRem;
                end
                StRem: begin
                    r_q     <= r_next;
                    state_q <= StFix;
                end
                StFix: begin
                    if (r_neg) begin
                        q_q <= q_q - 16'd1;
                        r_q <= r_q + {2'b00, d_q};
                    end else if (r_big) begin
                        q_q <= q_q + 16'd1;
                        r_q <= r_q - {2'b00, d_q};
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign q_out     = q_q;
    assign r_out     = r_q[15:0];
    assign dz_out    = dz_q;

endmodule

// File: tb/tb_nr_divide.sv
// Directed and random checks of nr_divide: results against floor division, latency,
// backpressure hold, divide-by-zero and mid-operation reset.
module tb_nr_divide;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] n_in = '0;
    logic [15:0] d_in = '0;
    logic [15:0] a_in = '0;
    logic [15:0] x_in = '0;
    logic [3:0]  s_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] q_out;
    logic [15:0] r_out;
    logic        dz_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat_lo;
        int          lat_hi;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    nr_divide #(.ITER(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_in      (n_in),
        .d_in      (d_in),
        .a_in      (a_in),
        .x_in      (x_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .r_out     (r_out),
        .dz_out    (dz_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // 32-entry seed table indexed by a[14:10]: 6-bit guess of 1/a at the bin centre, << 10.
    function automatic logic [15:0] seed_of(input logic [15:0] a);
        int idx;
        int mid;
        int g;
        idx = int'(a[14:10]);
        mid = 32'h8000 + idx * 1024 + 512;
        g   = (2097152 + mid / 2) / mid;
        if (g > 63) g = 63;
        return 16'(g << 10);
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic issue(input logic [15:0] n, input logic [15:0] d, input bit hold_valid,
                         input int lat_lo, input int lat_hi);
        exp_t        e;
        logic [15:0] a;
        logic [3:0]  s;
        int          guard;
        if (d == 16'd0) begin
            a = 16'($urandom);
            s = 4'($urandom);
            x_in = 16'($urandom);
            e.q = 16'hFFFF; e.r = n; e.dz = 1'b1; e.lat_lo = 1; e.lat_hi = 1;
        end else begin
            a = d;
            s = 4'd0;
            while (!a[15]) begin
                a = a << 1;
                s = s + 4'd1;
            end
            x_in = seed_of(a);
            e.q = n / d; e.r = n % d; e.dz = 1'b0; e.lat_lo = lat_lo; e.lat_hi = lat_hi;
        end
        n_in = n; d_in = d; a_in = a; s_in = s;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        sb.push_back(e);
        @(negedge clk);
        if (hold_valid) begin
            n_in = 16'($urandom); d_in = 16'($urandom); a_in = 16'($urandom);
            x_in = 16'($urandom); s_in = 4'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic collect(input int stall, input bit rand_ready);
        exp_t e;
        int   lat;
        e = sb.pop_front();
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_rise", 32'(out_valid), 32'd1);
        if (e.lat_lo == e.lat_hi) check("latency", 32'(lat), 32'(e.lat_lo));
        else check("latency_in_range", 32'(lat >= e.lat_lo && lat <= e.lat_hi), 32'd1);
        check("q_out", 32'(q_out), 32'(e.q));
        check("r_out", 32'(r_out), 32'(e.r));
        check("dz_out", 32'(dz_out), 32'(e.dz));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_q", 32'(q_out), 32'(e.q));
            check("hold_r", 32'(r_out), 32'(e.r));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (rand_ready) begin
            for (int i = 0; i < 4 && $urandom_range(0, 1) == 1; i++) begin
                out_ready = 1'b0;
                @(negedge clk);
                check("rand_hold_q", 32'(q_out), 32'(e.q));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] rn;
        logic [15:0] rd;

        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q_out), 32'd0);
        check("rst_r", 32'(r_out), 32'd0);
        check("rst_dz", 32'(dz_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(16'd100, 16'd7, 1'b0, 8, 8);
        collect(0, 1'b0);
        issue(16'd65535, 16'd1, 1'b0, 9, 9);
        collect(0, 1'b0);
        issue(16'd1234, 16'd0, 1'b0, 1, 1);
        collect(0, 1'b0);

        issue(16'd100, 16'd7, 1'b0, 8, 8);
        collect(10, 1'b0);

        // Reset while the second stage of the first iteration is in progress.
        issue(16'd100, 16'd7, 1'b0, 8, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q", 32'(q_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_dz", 32'(dz_out), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;

        issue(16'd50, 16'd5, 1'b0, 8, 10);
        collect(0, 1'b0);
        issue(16'd0, 16'd1, 1'b0, 8, 10);
        collect(0, 1'b0);
        issue(16'd65535, 16'd65535, 1'b0, 8, 10);
        collect(0, 1'b0);
        issue(16'd7, 16'd100, 1'b0, 8, 10);
        collect(0, 1'b0);
        issue(16'd65535, 16'd32767, 1'b0, 8, 10);
        collect(0, 1'b0);

        for (int t = 0; t < 2000; t++) begin
            rn = 16'($urandom_range(0, 65535));
            rd = 16'($urandom_range(1, 32767));
            issue(rn, rd, 1'b1, 8, 10);
            collect(0, 1'b1);
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
